// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the SS.hh stopwatch digit producer.
package stopwatch_pkg;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam logic [3:0] DP_MASK = 4'b0100;

  // Next BCD value; anything at or above 9 rolls to 0 so a digit never leaves 0..9.
  function automatic bcd_t bcd_next(input bcd_t d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw push-button to debounced level plus a one-cycle pulse on each accepted press.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] stable_cnt;
  logic          level_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync       <= '0;
      stable_cnt <= '0;
      level      <= 1'b0;
      level_d    <= 1'b0;
      press      <= 1'b0;
    end else begin
      sync    <= {sync[0], btn_in};
      level_d <= level;
      press   <= level & ~level_d;
      // Any sample agreeing with the current level restarts the stability count.
      if (sync[1] == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == LAST) begin
        level      <= sync[1];
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_digits.sv
// Start/stop/clear stopwatch counting SS.hh in BCD, driving a four-digit display word.
module stopwatch_digits
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ_HZ     = 100_000_000,
  parameter int TICK_HZ         = 100,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_start_stop,
  input  logic        btn_clear,
  output logic [15:0] data_out,
  output logic [3:0]  digit_display,
  output logic [3:0]  digit_point,
  output logic        running
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  state_t          state, state_next;
  logic [PW-1:0]   presc, presc_next;
  bcd_t [3:0]      digits, digits_next;
  logic            tick;
  logic            carry;
  logic            ss_level, ss_press;
  logic            clr_level, clr_press;
  logic            unused_levels;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_stop (
    .clk    (clk),
    .reset  (reset),
    .btn_in (btn_start_stop),
    .level  (ss_level),
    .press  (ss_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk    (clk),
    .reset  (reset),
    .btn_in (btn_clear),
    .level  (clr_level),
    .press  (clr_press)
  );

  // Only the press pulses drive the stopwatch; the held levels are not needed here.
  assign unused_levels = ss_level ^ clr_level;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_next  = state;
    presc_next  = presc;
    digits_next = digits;
    carry       = 1'b0;
    tick        = (state == RUNNING) && (presc == PRESC_LAST);

    // Prescaler holds while stopped so a pause keeps the partial hundredth.
    if (state == RUNNING) begin
      presc_next = tick ? '0 : presc + 1'b1;
    end

    if (tick) begin
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          digits_next[i] = bcd_next(digits[i]);
          carry          = (digits[i] == 4'd9);
        end
      end
    end

    if (ss_press) begin
      state_next = (state == RUNNING) ? STOPPED : RUNNING;
    end

    // Clear overrides a simultaneous start/stop press and a coinciding tick.
    if (clr_press) begin
      state_next  = STOPPED;
      presc_next  = '0;
      digits_next = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= STOPPED;
      presc         <= '0;
      digits        <= '0;
      digit_display <= 4'b0111;
    end else begin
      state         <= state_next;
      presc         <= presc_next;
      digits        <= digits_next;
      digit_display <= {digits_next[3] != 4'd0, 3'b111};
    end
  end

  assign data_out    = digits;
  assign digit_point = DP_MASK;
  assign running     = (state == RUNNING);

endmodule
